uart_rx_fifo: RTL and testbench

//  UART receive front end for the 50 MHz domain: synchronises uart_rx, deframes 8-bit characters
//  (optional parity) and queues them in a small FIFO presented on a valid/ready stream.

---
 rtl/uart_rx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receive front end: 2-flop line synchroniser, 8-bit deframer with optional
// parity, and a first-word-fall-through character FIFO on a valid/ready stream.
module uart_rx_fifo #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200,
   parameter int PARITY   = 0,
   parameter int FIFO_AW  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             uart_rx,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             frame_err,
   output logic             parity_err,
   output logic             overrun,
   output logic [FIFO_AW:0] fifo_level
);

   localparam int DIV   = CLK_FREQ / BAUD;
   localparam int HALF  = DIV / 2;
   localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

   logic [1:0]         sync_q;
   logic               rxs_prev_q;
   logic               rxs;
   logic               rx_fall;

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2:0]         bit_q;
   logic [7:0]         shift_q;
   logic               par_bad_q;
   logic               frame_err_q;
   logic               parity_err_q;
   logic               cnt_zero;

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q;
   logic [FIFO_AW-1:0] rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic [FIFO_AW:0]   count_d;
   logic [7:0]         last_q;
   logic               overrun_q;
   logic               stop_hit;
   logic               char_ok;
   logic               full;
   logic               push;
   logic               pop;

   // Sync flops preset to 1 so reset looks like an idle line, not a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= 2'b11;
         rxs_prev_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge value.
         sync_q     <= {sync_q[0], uart_rx};
         rxs_prev_q <= sync_q[1];
      end
   end

   assign rxs      = sync_q[1];
   assign rx_fall  = rxs_prev_q & ~rxs;
   assign cnt_zero = (cnt_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         par_bad_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A held-low break produces no new falling edge, so we re-arm only after rxs returns high.
               if (rx_fall) begin
                  state_q   <= S_START;
                  cnt_q     <= CW'(HALF - 1);
                  par_bad_q <= 1'b0;
               end
            end
            S_START: begin
               if (cnt_zero) begin
                  if (!rxs) begin
                     state_q <= S_DATA;
                     cnt_q   <= CW'(DIV - 1);
                     bit_q   <= '0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_zero) begin
                  shift_q <= {rxs, shift_q[7:1]};
                  cnt_q   <= CW'(DIV - 1);
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_PARITY: begin
               if (cnt_zero) begin
                  // Odd parity wants an odd count of ones across data plus parity bit.
                  par_bad_q <= ((^{shift_q, rxs}) != (PARITY == 1));
                  cnt_q     <= CW'(DIV - 1);
                  state_q   <= S_STOP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_STOP: begin
               if (cnt_zero) begin
                  frame_err_q  <= ~rxs;
                  parity_err_q <= par_bad_q;
                  state_q      <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stop_hit = (state_q == S_STOP) && cnt_zero;
   assign char_ok  = stop_hit & rxs & ~par_bad_q;
   assign full     = (count_q == (FIFO_AW + 1)'(DEPTH));
   assign pop      = rx_valid & rx_ready;
   assign push     = char_ok & (~full | pop);

   always_comb begin
      // NOTE: default assignment first keeps this block free of inferred latches.
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
         2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: character storage is not reset; rx_data shows last_q whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         last_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         overrun_q <= char_ok & full & ~pop;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            last_q   <= mem_q[rd_ptr_q];
         end
      end
   end

   assign rx_valid   = (count_q != '0);
   assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : last_q;
   assign fifo_level = count_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (PARITY 0/1/2) driven bit-by-bit and
// compared against a queue model of the character stream and error pulses.
module tb_uart_rx_fifo;

   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 3_125_000;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam int HALF     = DIV / 2;
   localparam int AW       = 2;
   localparam int DEPTH    = 2 ** AW;
   localparam int NDUT     = 3;
   localparam int MSZ      = 16;
   // Stop bit is sampled half a bit in, plus two sync flops and one edge-detect cycle.
   localparam int STOP_SAMPLE = HALF + 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          line  [NDUT];
   logic          ready [NDUT];
   logic [7:0]    data  [NDUT];
   logic          valid [NDUT];
   logic          fe    [NDUT];
   logic          pe    [NDUT];
   logic          ov    [NDUT];
   logic [AW:0]   level [NDUT];

   int            n_checks = 0;
   int            n_fail   = 0;

   logic [7:0]    mq [NDUT][MSZ];
   int            mhead [NDUT];
   int            mtail [NDUT];
   int            fe_n  [NDUT];
   int            pe_n  [NDUT];
   int            ov_n  [NDUT];
   int            vld_n [NDUT];
   logic          pv    [NDUT];
   logic [7:0]    pd    [NDUT];

   always #10 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      uart_rx_fifo #(
         .CLK_FREQ(CLK_FREQ),
         .BAUD    (BAUD),
         .PARITY  (g),
         .FIFO_AW (AW)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .uart_rx   (line[g]),
         .rx_data   (data[g]),
         .rx_valid  (valid[g]),
         .rx_ready  (ready[g]),
         .frame_err (fe[g]),
         .parity_err(pe[g]),
         .overrun   (ov[g]),
         .fifo_level(level[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and observe every instance 1 ns after the edge.
   task automatic step();
      logic [31:0] exp;
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         if (rst) begin
            pv[k] = 1'b0;
         end else begin
            if (pv[k] && ready[k]) begin
               exp = (mtail[k] > mhead[k]) ? {24'd0, mq[k][mhead[k] % MSZ]} : 32'h100;
               check($sformatf("pop_data[%0d]", k), {24'd0, pd[k]}, exp);
               if (mtail[k] > mhead[k]) mhead[k]++;
            end
            if (fe[k])    fe_n[k]++;
            if (pe[k])    pe_n[k]++;
            if (ov[k])    ov_n[k]++;
            if (valid[k]) vld_n[k]++;
            pv[k] = valid[k];
            pd[k] = data[k];
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic check_level(input int k);
      check($sformatf("level[%0d]", k), 32'(level[k]), 32'(mtail[k] - mhead[k]));
      check($sformatf("valid[%0d]", k), 32'(valid[k]), 32'(mtail[k] != mhead[k]));
   endtask

   // Drive one frame; the model decides the outcome from the frame contents and queue occupancy.
   task automatic send(input int k, input logic [7:0] b, input bit flip, input bit stop,
                       input bit rdy, input bit pop_at_push);
      int f0, p0, o0, cnt;
      bit par, exp_fe, exp_pe, exp_ov, good;
      f0 = fe_n[k]; p0 = pe_n[k]; o0 = ov_n[k];
      ready[k] = rdy;
      line[k] = 1'b0;
      repeat (DIV) step();
      for (int i = 0; i < 8; i++) begin
         line[k] = b[i];
         repeat (DIV) step();
      end
      if (k != 0) begin
         par = (k == 2) ? ^b : ~^b;
         line[k] = par ^ flip;
         repeat (DIV) step();
      end
      exp_fe = !stop;
      exp_pe = (k != 0) && flip;
      good   = stop && !exp_pe;
      cnt    = mtail[k] - mhead[k];
      exp_ov = good && (cnt >= DEPTH) && !pop_at_push;
      if (good && !exp_ov) begin
         mq[k][mtail[k] % MSZ] = b;
         mtail[k]++;
      end
      line[k] = stop;
      if (pop_at_push) begin
         repeat (STOP_SAMPLE - 1) step();
         ready[k] = 1'b1;
         step();
         ready[k] = 1'b0;
         repeat (DIV - STOP_SAMPLE) step();
      end else begin
         repeat (DIV) step();
      end
      line[k] = 1'b1;
      repeat (4) step();
      check($sformatf("frame_err[%0d]", k),  32'(fe_n[k] - f0), 32'(exp_fe));
      check($sformatf("parity_err[%0d]", k), 32'(pe_n[k] - p0), 32'(exp_pe));
      check($sformatf("overrun[%0d]", k),    32'(ov_n[k] - o0), 32'(exp_ov));
      check_level(k);
   endtask

   task automatic drain(input int k);
      ready[k] = 1'b1;
      idle(DEPTH + 3);
      ready[k] = 1'b0;
      check_level(k);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, p0, o0, v0;
      logic [7:0] b;
      bit flip, stop, rdy, pp;

      rst = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
         line[k] = 1'b1; ready[k] = 1'b0; mhead[k] = 0; mtail[k] = 0;
         fe_n[k] = 0; pe_n[k] = 0; ov_n[k] = 0; vld_n[k] = 0; pv[k] = 1'b0; pd[k] = 8'h0;
      end
      idle(4);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("rst_data[%0d]", k),  32'(data[k]),  32'h0);
         check($sformatf("rst_valid[%0d]", k), 32'(valid[k]), 32'h0);
         check($sformatf("rst_level[%0d]", k), 32'(level[k]), 32'h0);
         check($sformatf("rst_pulses[%0d]", k), 32'({fe[k], pe[k], ov[k]}), 32'h0);
      end
      rst = 1'b0;
      idle(4);

      // Single character with consumer ready: exactly one cycle of rx_valid.
      v0 = vld_n[0];
      send(0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
      check("valid_pulse_cycles", 32'(vld_n[0] - v0), 32'd1);

      // Fill to depth, overrun on the fifth, then drain in order.
      send(0, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
      send(0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      send(0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
      send(0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
      send(0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
      drain(0);
      check("data_hold_after_drain", 32'(data[0]), 32'h81);

      // Full FIFO with a pop in the push cycle: push succeeds, no overrun.
      for (int i = 0; i < DEPTH; i++) send(0, 8'(8'h40 + i), 1'b0, 1'b1, 1'b0, 1'b0);
      send(0, 8'hC7, 1'b0, 1'b1, 1'b0, 1'b1);
      drain(0);

      // Parity: even instance rejects a bad parity bit, then accepts the good one.
      send(2, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
      send(2, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
      send(1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
      send(1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
      drain(2);
      drain(1);

      // Framing error, then a clean character.
      send(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      send(0, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0);

      // Short glitch on the idle line.
      f0 = fe_n[0]; p0 = pe_n[0]; o0 = ov_n[0];
      line[0] = 1'b0;
      idle(5);
      line[0] = 1'b1;
      idle(3 * DIV);
      check("glitch_pulses", 32'((fe_n[0] - f0) + (pe_n[0] - p0) + (ov_n[0] - o0)), 32'd0);
      check_level(0);

      // Break: line held low for several frames gives exactly one framing error.
      f0 = fe_n[0];
      line[0] = 1'b0;
      idle(30 * DIV);
      line[0] = 1'b1;
      idle(2 * DIV);
      check("break_frame_err", 32'(fe_n[0] - f0), 32'd1);
      check_level(0);
      send(0, 8'h6E, 1'b0, 1'b1, 1'b1, 1'b0);

      // Reset during bit 4 with two characters queued.
      send(0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
      send(0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
      line[0] = 1'b0;
      idle(DIV);
      for (int i = 0; i < 4; i++) begin
         line[0] = 1'b0;
         idle(DIV);
      end
      line[0] = 1'b1;
      idle(HALF);
      rst = 1'b1;
      idle(3);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("midrst_out[%0d]", k),
               32'({data[k], valid[k], fe[k], pe[k], ov[k]}), 32'h0);
         check($sformatf("midrst_level[%0d]", k), 32'(level[k]), 32'h0);
         mhead[k] = mtail[k];
      end
      rst = 1'b0;
      f0 = fe_n[0]; p0 = pe_n[0]; o0 = ov_n[0];
      idle(2 * DIV);
      check("post_rst_pulses", 32'((fe_n[0] - f0) + (pe_n[0] - p0) + (ov_n[0] - o0)), 32'd0);
      send(0, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0);

      // Randomized traffic on every instance.
      for (int k = 0; k < NDUT; k++) begin
         for (int n = 0; n < 30; n++) begin
            b    = 8'($urandom);
            flip = (k != 0) && ($urandom_range(3) == 0);
            stop = ($urandom_range(7) != 0);
            rdy  = ($urandom_range(2) == 0);
            pp   = !rdy && ($urandom_range(4) == 0);
            send(k, b, flip, stop, rdy, pp);
            ready[k] = ($urandom_range(3) == 0);
            idle($urandom_range(10, 3));
         end
         drain(k);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
